// File: rtl/lut_gate_pkg.sv
// -----------------------------------------------------------------------------
// lut_gate_pkg
// Shared definitions for the LUT gate pipeline.
//   tt_t      : 4-bit two-input truth table, bit index is {a,b}
//   TT_*      : common gate functions expressed as truth tables
// -----------------------------------------------------------------------------
package lut_gate_pkg;

   typedef logic [3:0] tt_t;

   // Bit {a,b} of each constant is the gate output for that input pair.
   localparam tt_t TT_AND  = 4'b1000;
   localparam tt_t TT_OR   = 4'b1110;
   localparam tt_t TT_XOR  = 4'b0110;
   localparam tt_t TT_NAND = 4'b0111;
   localparam tt_t TT_NOR  = 4'b0001;

endpackage

// File: rtl/lut2_mux.sv
// -----------------------------------------------------------------------------
// lut2_mux
// One-bit two-input lookup: o_y = i_tt[{i_a,i_b}], built as a tree of three
// 2:1 muxes (i_b selects within each half, i_a selects the half).
//   i_tt : truth table
//   i_a  : operand bit a (upper index bit)
//   i_b  : operand bit b (lower index bit)
//   o_y  : selected truth-table bit
//
// mux2
// Plain 2:1 multiplexer: o_y = i_sel ? i_d1 : i_d0.
// -----------------------------------------------------------------------------
module lut2_mux
   import lut_gate_pkg::*;
(
   input  tt_t  i_tt,
   input  logic i_a,
   input  logic i_b,
   output logic o_y
);

   logic w_lo;   // a=0 half: tt[{0,b}]
   logic w_hi;   // a=1 half: tt[{1,b}]

   mux2 u_mux_lo (
      .i_d0  (i_tt[0]),
      .i_d1  (i_tt[1]),
      .i_sel (i_b),
      .o_y   (w_lo)
   );

   mux2 u_mux_hi (
      .i_d0  (i_tt[2]),
      .i_d1  (i_tt[3]),
      .i_sel (i_b),
      .o_y   (w_hi)
   );

   mux2 u_mux_out (
      .i_d0  (w_lo),
      .i_d1  (w_hi),
      .i_sel (i_a),
      .o_y   (o_y)
   );

endmodule

module mux2 (
   input  logic i_d0,
   input  logic i_d1,
   input  logic i_sel,
   output logic o_y
);

   assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/lut_gate_pipe.sv
// -----------------------------------------------------------------------------
// lut_gate_pipe
// Two-stage pipeline applying a programmable two-input gate bitwise to a pair
// of operands. Each transaction carries the truth table that was current when
// it was accepted, so reprogramming never disturbs in-flight data.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   cfg_we, cfg_tt      : truth-table write strobe and value (index {a,b})
//   in_valid/in_ready   : operand channel, operands in_a, in_b
//   out_valid/out_ready : result channel, result out_o
//   out_count           : number of completed output handshakes (wraps)
//   busy                : either pipeline stage holds valid data
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both 1. A producer holding valid keeps its data
// stable until the transfer. in_ready depends combinationally on out_ready.
// -----------------------------------------------------------------------------
module lut_gate_pipe
   import lut_gate_pkg::*;
#(
   parameter int  WIDTH    = 8,
   parameter int  CNT_W    = 16,
   parameter tt_t TT_RESET = TT_OR
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_tt,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_o,
   output logic [CNT_W-1:0] out_count,
   output logic             busy
);

   // Truth-table register and pipeline state
   tt_t              r_tt;
   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   tt_t              r_s1_tt;
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_s2_o;
   logic [CNT_W-1:0] r_count;

   logic             w_s2_can_load;
   logic             w_in_fire;
   logic             w_out_fire;
   logic [WIDTH-1:0] w_res;

   // S2 can take new data when empty or being drained this edge; S1 can take
   // new data when empty or advancing into S2.
   assign w_s2_can_load = !r_s2_valid || out_ready;
   assign in_ready      = !r_s1_valid || w_s2_can_load;
   assign w_in_fire     = in_valid && in_ready;
   assign w_out_fire    = r_s2_valid && out_ready;

   // The tt written on this edge lands in r_tt; an operand accepted on the
   // same edge captures the previous r_tt value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tt <= TT_RESET;
      end else if (cfg_we) begin
         r_tt <= cfg_tt;
      end
   end

   // Stage 1: operands plus the truth table they will be evaluated with
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_tt    <= TT_RESET;
      end else if (in_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_a  <= in_a;
            r_s1_b  <= in_b;
            r_s1_tt <= r_tt;
         end
      end
   end

   // Per-bit lookup between the stages; this mux tree is the whole datapath.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      lut2_mux u_lut (
         .i_tt (r_s1_tt),
         .i_a  (r_s1_a[gi]),
         .i_b  (r_s1_b[gi]),
         .o_y  (w_res[gi])
      );
   end

   // Stage 2: result register. Data only moves on a real S1 advance, so
   // out_o stays put while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_o     <= '0;
      end else if (w_s2_can_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_o <= w_res;
         end
      end
   end

   // Completed-result counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (w_out_fire) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign out_valid = r_s2_valid;
   assign out_o     = r_s2_o;
   assign out_count = r_count;
   assign busy      = r_s1_valid || r_s2_valid;

   // Accepted-input strobe kept for probing; not needed by the logic above.
   logic w_unused;
   assign w_unused = w_in_fire;

endmodule

// File: tb/tb_lut_gate_pipe.sv
// -----------------------------------------------------------------------------
// tb_lut_gate_pipe
// Scoreboarded bench for lut_gate_pipe. The driver pushes the expected result
// of each accepted operand pair; the monitor pops and compares on every
// output handshake. The reference model evaluates the truth table as a
// sum of minterms over whole words.
// -----------------------------------------------------------------------------
module tb_lut_gate_pipe;
   import lut_gate_pkg::*;

   localparam int W  = 8;
   localparam int CW = 4;

   // ---------------- clock / reset / DUT ----------------
   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          cfg_we    = 1'b0;
   logic [3:0]    cfg_tt    = 4'h0;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a      = '0;
   logic [W-1:0]  in_b      = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_o;
   logic [CW-1:0] out_count;
   logic          busy;

   always #5 clk = ~clk;

   lut_gate_pipe #(
      .WIDTH    (W),
      .CNT_W    (CW),
      .TT_RESET (TT_OR)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_tt    (cfg_tt),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_o     (out_o),
      .out_count (out_count),
      .busy      (busy)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int           n_tests = 0;
   int           n_fail  = 0;
   int           n_stall = 0;
   logic [W-1:0] exp_q[$];
   logic [3:0]   m_tt    = TT_OR;
   int           m_cnt   = 0;

   // Reference: OR together the minterms whose truth-table bit is set.
   function automatic logic [W-1:0] model(input logic [3:0] tt,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [W-1:0] r;
      r = '0;
      if (tt[3]) r = r | ( a &  b);
      if (tt[2]) r = r | ( a & ~b);
      if (tt[1]) r = r | (~a &  b);
      if (tt[0]) r = r | (~a & ~b);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (!rst_n) begin
         m_cnt = 0;
      end else if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got 0x%0h with nothing expected", out_o);
         end else begin
            e = exp_q.pop_front();
            check("result", out_o, e);
         end
         check("out_count", out_count, m_cnt[CW-1:0]);
         m_cnt = m_cnt + 1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      exp_q.delete();
      m_tt     = TT_OR;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Present one operand pair (optionally with a tt write) until accepted.
   // use_const selects a fixed expected value instead of the model.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic we, input logic [3:0] tt,
                       input bit use_const, input logic [W-1:0] exp_const);
      int waited;
      bit acc;
      waited   = 0;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      cfg_we   = we;
      cfg_tt   = tt;
      while (!acc) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(use_const ? exp_const : model(m_tt, a, b));
            acc = 1'b1;
         end
         @(posedge clk);
         #1;
         if (cfg_we) begin
            m_tt   = cfg_tt;
            cfg_we = 1'b0;
         end
         if (!acc) begin
            waited++;
            n_stall++;
            if (waited > 50) begin
               n_tests++;
               n_fail++;
               $display("FAIL accept_timeout: got no in_ready after %0d cycles, expected acceptance", waited);
               break;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c0;
      int s0;
      do_reset();

      // Reset state
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_out_count", out_count, 0);
      check("rst_out_o", out_o, 8'h00);
      check("rst_in_ready", in_ready, 1'b1);

      // OR default, two-cycle latency
      out_ready = 1'b1;
      send(8'hA5, 8'h0F, 1'b0, 4'h0, 1'b1, 8'hAF);
      check("lat_not_early", out_valid, 1'b0);
      @(posedge clk);
      #1;
      check("lat_valid", out_valid, 1'b1);
      check("lat_data", out_o, 8'hAF);
      wait_drain();
      check("count_after_one", out_count, 1);

      // tt write on the accepting edge uses the old table
      send(8'hFF, 8'h0F, 1'b1, TT_XOR, 1'b1, 8'hFF);
      send(8'hFF, 8'h0F, 1'b0, 4'h0,   1'b1, 8'hF0);
      wait_drain();

      // Backpressure: two accepted, third held off, output stable
      out_ready = 1'b0;
      send(8'h11, 8'h22, 1'b0, 4'h0, 1'b1, 8'h33);
      send(8'h33, 8'h0F, 1'b0, 4'h0, 1'b1, 8'h3C);
      in_valid = 1'b1;
      in_a     = 8'h44;
      in_b     = 8'h55;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 1'b0);
         check("stall_out_valid", out_valid, 1'b1);
         check("stall_out_hold", out_o, 8'h33);
         check("stall_busy", busy, 1'b1);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(8'h44, 8'h55, 1'b0, 4'h0, 1'b1, 8'h11);
      wait_drain();

      // Random back-to-back stream with occasional reprogramming
      c0 = cyc;
      s0 = n_stall;
      for (int i = 0; i < 100; i++) begin
         send(W'($urandom), W'($urandom), ($urandom_range(0, 7) == 0),
              4'($urandom_range(0, 15)), 1'b0, '0);
      end
      wait_drain();
      check("stream_cycles", cyc - c0, 102);
      check("stream_no_stall", n_stall - s0, 0);

      // Reset with both stages full under a non-default table
      send(8'h00, 8'h00, 1'b1, TT_AND, 1'b0, '0);
      wait_drain();
      out_ready = 1'b0;
      send(8'hC3, 8'h96, 1'b0, 4'h0, 1'b0, '0);
      send(8'h5A, 8'hA5, 1'b0, 4'h0, 1'b0, '0);
      check("full_busy", busy, 1'b1);
      check("full_out_valid", out_valid, 1'b1);
      check("full_in_ready", in_ready, 1'b0);
      #2 rst_n = 1'b0;
      exp_q.delete();
      m_tt = TT_OR;
      #1;
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_out_o", out_o, 8'h00);
      check("arst_out_count", out_count, 0);
      check("arst_in_ready", in_ready, 1'b1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_idle", out_valid, 1'b0);
      send(8'h3C, 8'h5A, 1'b0, 4'h0, 1'b1, 8'h7E);
      wait_drain();

      // Counter wrap with a 4-bit counter: 17 results leave it at 1
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         send(W'($urandom), W'($urandom), 1'b0, 4'h0, 1'b0, '0);
      end
      wait_drain();
      check("count_wrap", out_count, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lut_gate_pipe.md
LUT_GATE_PIPE -- requirements
Module: lut_gate_pipe

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, giving the operand and result bit width (legal range 1..64).
REQ-002 The block SHALL have the parameter CNT_W, default 16, giving the width of the completed-result counter.
REQ-003 The block SHALL have the parameter TT_RESET, default 4'b1110 (OR), giving the truth table loaded at reset.
REQ-004 The block SHALL have the port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have the port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have the port cfg_we, input, 1 bit, the truth-table write strobe.
REQ-007 The block SHALL have the port cfg_tt, input, 4 bits, the truth table; bit index is {a,b}.
REQ-008 The block SHALL have the ports in_valid (input, 1 bit), in_ready (output, 1 bit), in_a (input, WIDTH) and in_b (input, WIDTH) as the operand channel.
REQ-009 The block SHALL have the ports out_valid (output, 1 bit), out_ready (input, 1 bit) and out_o (output, WIDTH) as the result channel.
REQ-010 The block SHALL have the port out_count, output, CNT_W bits, counting completed output handshakes.
REQ-011 The block SHALL have the port busy, output, 1 bit, high while either pipeline stage holds valid data.

Function
REQ-012 Each result bit i SHALL be out_o[i] = tt[{a[i],b[i]}], where tt, a and b are the values captured with that transaction.
REQ-013 The truth-table register SHALL load cfg_tt on any edge with cfg_we=1, regardless of pipeline state.
REQ-014 A transaction accepted on the same edge as a cfg_we write SHALL use the truth-table value held before that edge.
REQ-015 Once accepted, a transaction's tt SHALL be fixed; later writes do not affect in-flight data.
REQ-016 An input handshake SHALL occur on an edge where in_valid=1 and in_ready=1; an output handshake SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-017 The pipeline SHALL have two register stages: S1 captures in_a, in_b and tt; S2 captures the computed result.
REQ-018 Latency SHALL be exactly 2 cycles: data accepted at edge k appears with out_valid=1 after edge k+1, given no stall.
REQ-019 Throughput SHALL be one transaction per cycle while out_ready=1.
REQ-020 S2 SHALL load when S2 is empty or an output handshake occurs; S1 SHALL load when S1 is empty or S1 advances into S2.
REQ-021 in_ready SHALL be !s1_valid || s2_can_load, where s2_can_load = !s2_valid || out_ready; in_ready may depend combinationally on out_ready.
REQ-022 While out_valid=1 and out_ready=0, out_o SHALL hold stable; no transaction is dropped, duplicated or reordered.
REQ-023 With both stages full and out_ready=0, in_ready SHALL be 0.
REQ-024 An input handshake and an output handshake on the same edge SHALL both complete.
REQ-025 out_count SHALL increment by 1 on each output handshake and wrap from 2^CNT_W-1 to 0.
REQ-026 in_valid=1 with in_ready=0 SHALL cause no state change.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force s1_valid=0, s2_valid=0, out_valid=0, busy=0, out_count=0, out_o=0 and tt=TT_RESET.
REQ-028 After reset, in_ready SHALL be 1.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight transactions; none appear after reset deassertion.
REQ-030 Reset deassertion SHALL take effect at the next rising edge of clk, with rst_n synchronised externally.

Structure
REQ-031 A shared package lut_gate_pkg SHALL hold the 4-bit truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111 and TT_NOR=4'b0001.
REQ-032 A sub-module lut2_mux SHALL implement a 4:1 selection of the tt bits by {a,b}, built from three 2:1 mux instances.
REQ-033 lut2_mux SHALL be instantiated once per bit via generate.
REQ-034 The datapath SHALL contain no inferred logic operators beyond the mux tree.

Verification
REQ-035 The bench SHALL reset to the OR default, then send a=8'hA5, b=8'h0F with out_ready=1; required response: out_o=8'hAF with out_valid two cycles after acceptance, and out_count=1.
REQ-036 The bench SHALL write cfg_tt=TT_XOR on the same edge as accepting a=8'hFF, b=8'h0F, then accept a=8'hFF, b=8'h0F again; required response: first result 8'hFF (old OR), second result 8'hF0.
REQ-037 The bench SHALL hold out_ready=0 while sending 3 transactions; required response: exactly 2 are accepted, in_ready=0, and out_o is stable. After out_ready=1 it SHALL observe all 3 in order with no loss.
REQ-038 The bench SHALL stream 100 back-to-back random transactions with out_ready=1; required response: one result per cycle, each matching a reference model.
REQ-039 The bench SHALL preset the counter near wrap using CNT_W=4 and send 17 transactions; required response: out_count reads 1.
REQ-040 The bench SHALL pull rst_n low while both stages are full; required response: out_valid and busy drop immediately, tt=TT_RESET, and no stale result emerges after reset.
